// File: rtl/mem_responder.sv
// mem_responder: instruction/data memory responder with fixed latency, data-priority grant and abort on request change.
module mem_responder #(
  parameter int LAT = 2,
  parameter int AW = 8
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic gnt_q, gnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic wr_q, wr_d;
  logic [31:0] mem_q [2**AW];
  logic [AW-1:0] iidx, didx;
  logic dreq, greq, ok, fin;
  logic unused_bits;
  assign iidx = iaddr[AW+1:2];
  assign didx = daddr[AW+1:2];
  assign unused_bits = ^{iaddr[31:AW+2], iaddr[1:0], daddr[31:AW+2], daddr[1:0]};
  assign dreq = dREN | dWEN;
  // the granted port must keep its request and word address or the transfer aborts
  assign greq = gnt_q ? dreq : iREN;
  assign ok = greq && ((gnt_q ? didx : iidx) == addr_q);
  assign fin = (state_q == DONE) && ok;
  assign iwait = !(fin && !gnt_q);
  assign dwait = !(fin && gnt_q);
  assign iload = (fin && !gnt_q) ? mem_q[addr_q] : '0;
  assign dload = (fin && gnt_q && !wr_q) ? mem_q[addr_q] : '0;
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q <= '0;
      gnt_q <= 1'b1;
      addr_q <= '0;
      wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      gnt_q <= gnt_d;
      addr_q <= addr_d;
      wr_q <= wr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    gnt_d = gnt_q;
    addr_d = addr_q;
    wr_d = wr_q;
    case (state_q)
      IDLE: if (dreq || iREN) begin
        gnt_d = dreq;
        addr_d = dreq ? didx : iidx;
        wr_d = dreq && dWEN;
        cnt_d = 4'(LAT);
        state_d = (LAT == 0) ? DONE : BUSY;
      end
      BUSY: if (!ok) state_d = IDLE;
      else begin
        cnt_d = cnt_q - 4'd1;
        state_d = (cnt_q == 4'd1) ? DONE : BUSY;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < 2**AW; i++) mem_q[i] <= '0;
    end else if (fin && gnt_q && wr_q) begin
      mem_q[addr_q] <= dstore;
    end
  end
endmodule
